// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- four-source vectored interrupt controller
//
// The controller latches rising edges on four request lines into a pending
// register. It arbitrates the enabled pending requests with fixed priority,
// where the lowest index wins. The winner is announced to the CPU for exactly
// one cycle: the current PC is pushed and the PC is loaded with the handler
// vector. The controller then waits in service until the control unit
// signals return-from-interrupt. Handlers do not nest. Requests that arrive
// while a handler runs only accumulate in the pending register.
//
// Parameters
//   VEC_BASE    program address of the source 0 handler
//   VEC_STRIDE  address spacing between consecutive source handlers
//
// Ports
//   clk         clock; all state changes on its rising edge
//   reset       asynchronous active-high reset
//   irq         interrupt request lines; bit 0 has the highest priority
//   we_mask     write strobe for the mask register
//   mask_in     new mask value; bit i = 1 enables source i
//   reti        return-from-interrupt strobe, one cycle wide
//   oflow       return-address stack overflow; blocks new interrupts
//   interrupt   pushes the current PC on the return-address stack
//   s_vec       selects vector into the PC next-address mux
//   vector      handler address for active_id
//   in_service  high while a handler is being entered or is executing
//   active_id   index of the source being serviced or last serviced
//   pending     pending-request register
//   mask        current mask register
// -----------------------------------------------------------------------------
module int_ctrl #(
   parameter logic [9:0] VEC_BASE   = 10'd1000,
   parameter logic [9:0] VEC_STRIDE = 10'd4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] irq,
   input  logic       we_mask,
   input  logic [3:0] mask_in,
   input  logic       reti,
   input  logic       oflow,
   output logic       interrupt,
   output logic       s_vec,
   output logic [9:0] vector,
   output logic       in_service,
   output logic [1:0] active_id,
   output logic [3:0] pending,
   output logic [3:0] mask
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TAKE    = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [3:0] irq_prev_reg;
   logic [3:0] pending_reg, pending_next;
   logic [3:0] mask_reg, mask_next;
   logic [1:0] active_id_reg, active_id_next;

   logic [3:0] irq_edge;      // one-cycle rising-edge pulses
   logic [3:0] eligible;      // pending and enabled
   logic [1:0] sel_id;        // lowest-index eligible source
   logic       take_start;    // IDLE -> TAKE at this edge
   logic [3:0] take_onehot;   // pending bit being consumed by this take

   // Arbitration always sees the mask as it stands now. A mask write in this
   // cycle only affects arbitration from the next cycle onwards.
   assign eligible = pending_reg & mask_reg;

   always_comb begin
      sel_id = 2'd0;
      casez (eligible)
         4'b???1: sel_id = 2'd0;
         4'b??10: sel_id = 2'd1;
         4'b?100: sel_id = 2'd2;
         4'b1000: sel_id = 2'd3;
         default: sel_id = 2'd0;
      endcase
   end

   // Per-source edge detection and pending update. A new edge wins over the
   // clear of the bit being taken. A request that re-arrives exactly as it is
   // accepted is therefore not lost.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_src
         assign irq_edge[gi]     = irq[gi] & ~irq_prev_reg[gi];
         assign take_onehot[gi]  = take_start & (sel_id == 2'(gi));
         assign pending_next[gi] = irq_edge[gi] | (pending_reg[gi] & ~take_onehot[gi]);
      end
   endgenerate

   // Next-state logic and state-decoded outputs.
   always_comb begin
      state_next = state_reg;
      take_start = 1'b0;
      interrupt  = 1'b0;
      s_vec      = 1'b0;
      in_service = 1'b0;
      unique case (state_reg)
         IDLE: begin
            // A full return-address stack blocks entry. The request stays
            // pending until the stack has room again.
            if ((|eligible) && !oflow) begin
               state_next = TAKE;
               take_start = 1'b1;
            end
         end
         TAKE: begin
            interrupt  = 1'b1;
            s_vec      = 1'b1;
            in_service = 1'b1;
            state_next = SERVICE;
         end
         SERVICE: begin
            in_service = 1'b1;
            if (reti) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mask_next      = we_mask ? mask_in : mask_reg;
   assign active_id_next = take_start ? sel_id : active_id_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         irq_prev_reg  <= 4'd0;
         pending_reg   <= 4'd0;
         mask_reg      <= 4'd0;
         active_id_reg <= 2'd0;
      end else begin
         state_reg     <= state_next;
         irq_prev_reg  <= irq;
         pending_reg   <= pending_next;
         mask_reg      <= mask_next;
         active_id_reg <= active_id_next;
      end
   end

   // The vector always follows active_id. The arithmetic is 10 bits wide, so
   // addresses past the top of program memory wrap around.
   assign vector    = VEC_BASE + 10'(active_id_reg) * VEC_STRIDE;
   assign active_id = active_id_reg;
   assign pending   = pending_reg;
   assign mask      = mask_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl -- self-checking bench for int_ctrl
//
// A behavioural model tracks pending, mask, handler activity and the serviced
// source. A compare process checks every DUT output against the model on each
// falling clock edge. Directed scenarios add literal expectations, and a
// randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

   localparam int VB = 1000;
   localparam int VS = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq;
   logic       we_mask;
   logic [3:0] mask_in;
   logic       reti;
   logic       oflow;
   logic       interrupt;
   logic       s_vec;
   logic [9:0] vector;
   logic       in_service;
   logic [1:0] active_id;
   logic [3:0] pending;
   logic [3:0] mask;

   int_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .we_mask    (we_mask),
      .mask_in    (mask_in),
      .reti       (reti),
      .oflow      (oflow),
      .interrupt  (interrupt),
      .s_vec      (s_vec),
      .vector     (vector),
      .in_service (in_service),
      .active_id  (active_id),
      .pending    (pending),
      .mask       (mask)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_take = 0;
   bit checking = 1'b0;

   // Behavioural model state.
   bit [3:0] m_irq_prev;
   bit [3:0] m_pending;
   bit [3:0] m_mask;
   int       m_active;
   bit       m_busy;      // a handler has been accepted and not yet returned
   bit       m_entering;  // first cycle after acceptance

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_irq_prev = '0;
      m_pending  = '0;
      m_mask     = '0;
      m_active   = 0;
      m_busy     = 1'b0;
      m_entering = 1'b0;
   endtask

   // Applies one rising clock edge to the model, using the inputs as they
   // stood at that edge.
   task automatic model_step();
      bit [3:0] edges;
      bit [3:0] np;
      bit [3:0] cand;
      int k;
      if (reset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 4; i++) edges[i] = irq[i] && !m_irq_prev[i];
      np = m_pending;
      if (!m_busy) begin
         cand = m_pending & m_mask;
         if (cand != 0 && !oflow) begin
            k = 0;
            while (!cand[k]) k++;
            m_active   = k;
            np[k]      = 1'b0;
            m_busy     = 1'b1;
            m_entering = 1'b1;
            n_take++;
            $display("[%0t] take #%0d: source %0d, vector %0d", $time, n_take, k,
                     (VB + k * VS) % 1024);
         end
      end else if (m_entering) begin
         m_entering = 1'b0;
      end else if (reti) begin
         m_busy = 1'b0;
      end
      m_pending  = np | edges;
      m_mask     = we_mask ? mask_in : m_mask;
      m_irq_prev = irq;
   endtask

   task automatic compare_all();
      chk("interrupt",  int'(interrupt),  int'(m_busy && m_entering));
      chk("s_vec",      int'(s_vec),      int'(m_busy && m_entering));
      chk("in_service", int'(in_service), int'(m_busy));
      chk("vector",     int'(vector),     (VB + m_active * VS) % 1024);
      chk("active_id",  int'(active_id),  m_active);
      chk("pending",    int'(pending),    int'(m_pending));
      chk("mask",       int'(mask),       int'(m_mask));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (checking) compare_all();
      end
   end

   // Drives one cycle of inputs, then advances through the next rising edge.
   task automatic cyc(input logic [3:0] i_irq, input logic i_we, input logic [3:0] i_mask,
                      input logic i_reti, input logic i_oflow);
      irq     = i_irq;
      we_mask = i_we;
      mask_in = i_mask;
      reti    = i_reti;
      oflow   = i_oflow;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic async_reset_pulse();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] r_irq;
      logic [3:0] r_tog;
      reset   = 1'b1;
      irq     = '0;
      we_mask = 1'b0;
      mask_in = '0;
      reti    = 1'b0;
      oflow   = 1'b0;
      model_reset();
      #2;
      chk("reset in_service", int'(in_service), 0);
      chk("reset interrupt",  int'(interrupt),  0);
      chk("reset vector",     int'(vector),     1000);
      chk("reset pending",    int'(pending),    0);
      checking = 1'b1;
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;

      // Single source 2 request.
      cyc(4'd0, 1'b1, 4'hF, 1'b0, 1'b0);
      cyc(4'b0100, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("s2 pending", int'(pending), 4);
      chk("s2 no int yet", int'(interrupt), 0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("s2 interrupt", int'(interrupt), 1);
      chk("s2 s_vec", int'(s_vec), 1);
      chk("s2 vector", int'(vector), 1008);
      chk("s2 active_id", int'(active_id), 2);
      chk("s2 pending clr", int'(pending), 0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("s2 service int", int'(interrupt), 0);
      chk("s2 service", int'(in_service), 1);
      cyc(4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
      chk("s2 returned", int'(in_service), 0);

      // Sources 3 and 1 together: 1 first, then 3 straight after return.
      cyc(4'b1010, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("pri vector1", int'(vector), 1004);
      chk("pri pending3", int'(pending), 8);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
      chk("pri idle gap", int'(in_service), 0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("pri int3", int'(interrupt), 1);
      chk("pri vector3", int'(vector), 1012);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b1, 1'b0);

      // Masked request is latched; a later mask write releases it.
      cyc(4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
      cyc(4'b0001, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("masked pending", int'(pending), 1);
      chk("masked idle", int'(in_service), 0);
      cyc(4'd0, 1'b1, 4'b0001, 1'b0, 1'b0);
      chk("mask write no take", int'(in_service), 0);
      chk("mask written", int'(mask), 1);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("unmasked take", int'(interrupt), 1);
      chk("unmasked vector", int'(vector), 1000);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b1, 1'b0);

      // Stack overflow holds off entry.
      cyc(4'b0001, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      chk("oflow hold", int'(in_service), 0);
      chk("oflow pending", int'(pending), 1);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("oflow release", int'(interrupt), 1);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b1, 1'b0);

      // Re-request during service, then reti in IDLE.
      cyc(4'b0001, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'b0001, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("renew no nest", int'(interrupt), 0);
      chk("renew pending", int'(pending), 1);
      cyc(4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("retake", int'(interrupt), 1);
      chk("retake id", int'(active_id), 0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
      chk("idle reti", int'(in_service), 0);
      chk("idle reti pend", int'(pending), 0);

      // Asynchronous reset in the middle of service.
      cyc(4'b0001, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(4'b0010, 1'b0, 4'd0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("arst in_service", int'(in_service), 0);
      chk("arst pending", int'(pending), 0);
      chk("arst mask", int'(mask), 0);
      chk("arst vector", int'(vector), 1000);
      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      #2;
      reset = 1'b0;

      // Randomized traffic.
      r_irq = '0;
      for (int c = 0; c < 3000; c++) begin
         r_tog = 4'($urandom) & 4'($urandom) & 4'($urandom);
         r_irq = r_irq ^ r_tog;
         cyc(r_irq, ($urandom_range(0, 9) == 0), 4'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 299) == 0) async_reset_pulse();
      end

      cyc(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
